// File: rtl/dp_operand_sequencer_if.sv
// Operand stream bundle: producer-side valid/ready triple and consumer-side issued operands.
// master = producer/consumer environment, slave = dp_operand_sequencer.
interface dp_operand_sequencer_if #(
    parameter int DATAWIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] in_a;
    logic [DATAWIDTH-1:0] in_b;
    logic [DATAWIDTH-1:0] in_c;
    logic                 down_ready;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [DATAWIDTH-1:0] c;
    logic                 issue;
    logic                 res_valid;

    modport master (
        output in_valid, in_a, in_b, in_c, down_ready,
        input  in_ready, a, b, c, issue, res_valid
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, down_ready,
        output in_ready, a, b, c, issue, res_valid
    );
endinterface

// File: rtl/dp_operand_sequencer.sv
// FIFO-buffered operand feeder for the registered a/b/c -> z/x datapath; res_valid tracks datapath latency.
// Optional macro SEQ_ISSUE_COUNT_EN adds a free-running 16-bit issue_cnt output.
module dp_operand_sequencer #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    dp_operand_sequencer_if.slave   bus,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  fifo_count
`ifdef SEQ_ISSUE_COUNT_EN
    ,
    output logic [15:0]             issue_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 3 * DATAWIDTH;

    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [EW-1:0]        mem_q [DEPTH];
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DATAWIDTH-1:0] a_q, a_d;
    logic [DATAWIDTH-1:0] b_q, b_d;
    logic [DATAWIDTH-1:0] c_q, c_d;
    logic                 issue_q, issue_d;
    logic [LATENCY-1:0]   dly_q, dly_d;
    logic [0:0]           state;
    logic                 push;
    logic                 pop;

    // Control state is carried by occupancy itself, so it can never disagree with count.
    assign state        = (count_q == '0) ? ST_EMPTY : ST_ACTIVE;
    assign bus.in_ready = Rst & (count_q < CW'(DEPTH));
    assign push         = bus.in_valid & bus.in_ready & ~flush;
    assign pop          = (state == ST_ACTIVE) & bus.down_ready & ~flush;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    // The operand registers double as the RAM's registered read port.
    always_comb begin
        {a_d, b_d, c_d} = {a_q, b_q, c_q};
        if (pop) begin
            {a_d, b_d, c_d} = mem_q[rd_ptr_q];
        end
        issue_d = pop;
    end

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_dly
            if (gi == 0) begin : g_first
                assign dly_d[gi] = issue_q;
            end else begin : g_rest
                assign dly_d[gi] = dly_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b, bus.in_c};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            issue_q  <= 1'b0;
            dly_q    <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            issue_q  <= issue_d;
            dly_q    <= dly_d;
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.c         = c_q;
    assign bus.issue     = issue_q;
    assign bus.res_valid = dly_q[LATENCY-1];
    assign fifo_count    = count_q;

`ifdef SEQ_ISSUE_COUNT_EN
    logic [15:0] issue_cnt_q, issue_cnt_d;

    // Flush leaves the counter alone; only reset clears it.
    always_comb begin
        issue_cnt_d = issue_cnt_q + 16'(issue_q);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            issue_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
`endif
endmodule

// File: tb/tb_dp_operand_sequencer.sv
// Bench for dp_operand_sequencer: directed scenarios plus random traffic against a queue-based model.
// Build with SEQ_ISSUE_COUNT_EN defined to also cover issue_cnt.
module tb_dp_operand_sequencer;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] fifo_count;
`ifdef SEQ_ISSUE_COUNT_EN
    logic [15:0] issue_cnt;
`endif

    dp_operand_sequencer_if #(.DATAWIDTH(DW)) bus ();

    dp_operand_sequencer #(
        .DATAWIDTH(DW),
        .DEPTH    (DEPTH),
        .LATENCY  (LAT)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .bus       (bus),
        .flush     (flush),
        .fifo_count(fifo_count)
`ifdef SEQ_ISSUE_COUNT_EN
        ,
        .issue_cnt (issue_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } trip_t;

    // Reference model: FIFO as a queue, last issued triple, issue flag, res_valid pipe.
    trip_t       fifo_m[$];
    trip_t       m_out;
    bit          m_issue;
    bit          m_pipe[LAT];
    int unsigned m_cnt;
    trip_t       seen[$];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [127:0] exp_vec();
        return {m_out, m_issue, m_pipe[LAT-1], 3'(fifo_m.size()),
                1'(Rst && (fifo_m.size() < DEPTH))
`ifdef SEQ_ISSUE_COUNT_EN
                , 16'(m_cnt)
`endif
               };
    endfunction

    function automatic logic [127:0] dut_vec();
        return {bus.a, bus.b, bus.c, bus.issue, bus.res_valid, fifo_count, bus.in_ready
`ifdef SEQ_ISSUE_COUNT_EN
                , issue_cnt
`endif
               };
    endfunction

    task automatic drive(input bit v, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        bus.in_valid = v;
        bus.in_a     = x;
        bus.in_b     = y;
        bus.in_c     = z;
    endtask

    // Advances one clock edge and applies the same edge to the model.
    task automatic step();
        bit    push, pop;
        trip_t t;
        push = Rst && bus.in_valid && (fifo_m.size() < DEPTH) && !flush;
        pop  = Rst && (fifo_m.size() > 0) && bus.down_ready && !flush;
        t    = {bus.in_a, bus.in_b, bus.in_c};
        if (!Rst) begin
            fifo_m.delete();
            m_out   = '0;
            m_issue = 1'b0;
            foreach (m_pipe[i]) m_pipe[i] = 1'b0;
            m_cnt   = 0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = m_issue;
            if (m_issue) m_cnt = (m_cnt + 1) % 65536;
            m_issue = pop;
            if (pop) m_out = fifo_m.pop_front();
            if (flush) fifo_m.delete();
            else if (push) fifo_m.push_back(t);
        end
        @(posedge Clk);
        #1;
        if (bus.issue === 1'b1) begin
            seen.push_back({bus.a, bus.b, bus.c});
            $display("issue a=%h b=%h c=%h count=%0d", bus.a, bus.b, bus.c, fifo_count);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        bus.down_ready = 1'b1;
        drive(1'b1, 32'h1, 32'h2, 32'h3);
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        step();
        step();
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), exp_vec());
        end
        n_vec++;
        if ({bus.a, bus.b, bus.c, bus.issue, bus.res_valid, fifo_count} !== '0) begin
            n_err++;
            $display("FAIL reset_zero: got a=%h b=%h c=%h iss=%b rv=%b cnt=%0d want all 0",
                     bus.a, bus.b, bus.c, bus.issue, bus.res_valid, fifo_count);
        end
        drive(1'b0, 0, 0, 0);
    endtask

    task automatic test_single();
        Rst = 1'b1;
        bus.down_ready = 1'b1;
        drive(1'b1, 32'd5, 32'd3, 32'd7);
        step();
        drive(1'b0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL single_cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (i == 0) begin
                n_vec++;
                if ({bus.a, bus.b, bus.c, bus.issue} !== {32'd5, 32'd3, 32'd7, 1'b1}) begin
                    n_err++;
                    $display("FAIL single_issue: got %0d/%0d/%0d iss=%b want 5/3/7 iss=1",
                             bus.a, bus.b, bus.c, bus.issue);
                end
            end
            if (i == 1) begin
                n_vec++;
                if ({bus.res_valid, bus.issue, fifo_count} !== {1'b1, 1'b0, 3'd0}) begin
                    n_err++;
                    $display("FAIL single_res: got rv=%b iss=%b cnt=%0d want rv=1 iss=0 cnt=0",
                             bus.res_valid, bus.issue, fifo_count);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        bit acc;
        seen.delete();
        bus.down_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(k < 5, 32'h10 + k, 32'h110 + k, 32'h210 + k);
            if (fifo_count == 3'd4) begin
                n_vec++;
                if (bus.in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_full_ready: got %b want 0", bus.in_ready);
                end
            end
            acc = bus.in_valid && bus.in_ready;
            step();
            if (acc) k++;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL bp_fill_cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (k != 4) begin
            n_err++;
            $display("FAIL bp_accepted: got %0d want 4", k);
        end
        bus.down_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(k < 5, 32'h10 + k, 32'h110 + k, 32'h210 + k);
            acc = bus.in_valid && bus.in_ready;
            step();
            if (acc) k++;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL bp_drain_cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (seen.size() != 5) begin
            n_err++;
            $display("FAIL bp_issue_count: got %0d want 5", seen.size());
        end
        for (int j = 0; j < seen.size() && j < 5; j++) begin
            n_vec++;
            if (seen[j] !== {32'h10 + j, 32'h110 + j, 32'h210 + j}) begin
                n_err++;
                $display("FAIL bp_order%0d: got %h want a=%h", j, seen[j], 32'h10 + j);
            end
        end
        drive(1'b0, 0, 0, 0);
    endtask

    task automatic test_stream();
        seen.delete();
        bus.down_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) bus.down_ready = 1'b1;
            drive(1'b1, i, i + 100, i + 200);
            step();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL stream_cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (i >= 2) begin
                n_vec++;
                if (fifo_count !== 3'd2) begin
                    n_err++;
                    $display("FAIL stream_count%0d: got %0d want 2", i, fifo_count);
                end
            end
        end
        drive(1'b0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL stream_drain%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (seen.size() != 8) begin
            n_err++;
            $display("FAIL stream_issue_count: got %0d want 8", seen.size());
        end
        for (int j = 0; j < seen.size() && j < 8; j++) begin
            n_vec++;
            if (seen[j] !== {32'(j), 32'(j + 100), 32'(j + 200)}) begin
                n_err++;
                $display("FAIL stream_order%0d: got %h want a=%0d", j, seen[j], j);
            end
        end
    endtask

    task automatic test_empty_hold();
        bus.down_ready = 1'b1;
        drive(1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
        step();
        drive(1'b0, 0, 0, 0);
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if ({bus.a, bus.b, bus.c, bus.issue, bus.res_valid} !==
                {32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL empty_hold%0d: got a=%h b=%h c=%h iss=%b rv=%b", i,
                         bus.a, bus.b, bus.c, bus.issue, bus.res_valid);
            end
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL empty_model%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_flush();
        int res_cnt = 0;
        int iss_cnt = 0;
        bus.down_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h20 + i, 32'h120 + i, 32'h220 + i);
            step();
        end
        drive(1'b0, 0, 0, 0);
        bus.down_ready = 1'b1;
        step();
        bus.down_ready = 1'b0;
        flush = 1'b1;
        drive(1'b1, 32'h99, 32'h99, 32'h99);
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_in_ready: got %b want 1", bus.in_ready);
        end
        step();
        flush = 1'b0;
        drive(1'b0, 0, 0, 0);
        bus.down_ready = 1'b1;
        res_cnt += int'(bus.res_valid);
        n_vec++;
        if (fifo_count !== 3'd0) begin
            n_err++;
            $display("FAIL flush_count: got %0d want 0", fifo_count);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            res_cnt += int'(bus.res_valid);
            iss_cnt += int'(bus.issue);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL flush_cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (res_cnt != 1 || iss_cnt != 0) begin
            n_err++;
            $display("FAIL flush_pulses: got res=%0d iss=%0d want res=1 iss=0", res_cnt, iss_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int got = 0;
        Rst = 1'b0;
        step();
        Rst = 1'b1;
        bus.down_ready = 1'b1;
        for (int i = 0; i < 12 && got < 3; i++) begin
            drive(k < 5, 32'h30 + k, 32'h130 + k, 32'h230 + k);
            if (bus.in_valid && bus.in_ready) k++;
            step();
            got += int'(bus.issue);
        end
        n_vec++;
        if (got != 3) begin
            n_err++;
            $display("FAIL mid_issues: got %0d want 3 within budget", got);
        end
        drive(1'b0, 0, 0, 0);
        step();
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL mid_pre: got %h want %h", dut_vec(), exp_vec());
        end
`ifdef SEQ_ISSUE_COUNT_EN
        n_vec++;
        if (issue_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL mid_issue_cnt: got %0d want 3", issue_cnt);
        end
`endif
        Rst = 1'b0;
        drive(1'b1, 32'h77, 32'h77, 32'h77);
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_ready_in_reset: got %b want 0", bus.in_ready);
        end
        step();
        n_vec++;
        if ({bus.a, bus.b, bus.c, bus.issue, bus.res_valid, fifo_count} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_zero: got a=%h iss=%b rv=%b cnt=%0d want 0",
                     bus.a, bus.issue, bus.res_valid, fifo_count);
        end
`ifdef SEQ_ISSUE_COUNT_EN
        n_vec++;
        if (issue_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL mid_cnt_zero: got %0d want 0", issue_cnt);
        end
`endif
        Rst = 1'b1;
        drive(1'b0, 0, 0, 0);
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_ready_after: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_random();
        Rst = 1'b1;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom);
            bus.down_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            step();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random_cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        flush = 1'b0;
        drive(1'b0, 0, 0, 0);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_c       = '0;
        bus.down_ready = 1'b0;
        m_out   = '0;
        m_issue = 1'b0;
        foreach (m_pipe[i]) m_pipe[i] = 1'b0;
        m_cnt   = 0;
        @(posedge Clk);
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_empty_hold();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
